// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-stage access sequencer.
package mem_stage_pkg;

    localparam int unsigned ARQ_DEF              = 16;
    localparam int unsigned MEMORY_ADDR_SIZE_DEF = 13;
    localparam int unsigned TIMEOUT_DEF          = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_TIMEOUT  = 2'b01,
        FAULT_RANGE    = 2'b10,
        FAULT_CONFLICT = 2'b11
    } fault_code_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus between the memory-stage sequencer (master) and the memory (slave).
interface mem_stage_ctrl_if
    import mem_stage_pkg::*;
#(
    parameter int unsigned ARQ              = ARQ_DEF,
    parameter int unsigned MEMORY_ADDR_SIZE = MEMORY_ADDR_SIZE_DEF
);
    logic                        mem_req;
    logic                        mem_we;
    logic [MEMORY_ADDR_SIZE-1:0] mem_addr;
    logic [ARQ-1:0]              mem_wdata;
    logic                        mem_ack;
    logic [ARQ-1:0]              mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_timeout_cnt.sv
// Saturating wait counter; hit flags the cycle whose increment reaches TIMEOUT.
module mem_timeout_cnt
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Asserted in the TIMEOUT-th unacknowledged cycle so req is held exactly TIMEOUT cycles.
    assign hit = en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: turns one-cycle load/store requests into a req/ack
// transaction, stalling upstream and flagging range, conflict and timeout faults.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned ARQ              = ARQ_DEF,
    parameter int unsigned MEMORY_ADDR_SIZE = MEMORY_ADDR_SIZE_DEF,
    parameter int unsigned TIMEOUT          = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rd_en_in,
    input  logic           wr_en_in,
    input  logic           mux_sel_in,
    input  logic [ARQ-1:0] addr_in,
    input  logic [ARQ-1:0] data_alu_in,
    input  logic [ARQ-1:0] data_reg_in,
    input  logic           wb_en_in,
    input  logic           pc_en_in,
    mem_stage_ctrl_if.master mem,
    output logic           stall,
    output logic           rd_valid,
    output logic [ARQ-1:0] rd_data,
    output logic [ARQ-1:0] alu_result_out,
    output logic           wb_en_out,
    output logic           pc_en_out,
    output logic           fault,
    output logic [1:0]     fault_code
);
    state_t                      state_q, state_d;
    logic                        mem_req_q, mem_req_d;
    logic                        mem_we_q, mem_we_d;
    logic [MEMORY_ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [ARQ-1:0]              mem_wdata_q, mem_wdata_d;
    logic                        rd_valid_q, rd_valid_d;
    logic [ARQ-1:0]              rd_data_q, rd_data_d;
    logic                        fault_q, fault_d;
    fault_code_t                 code_q, code_d;
    fault_code_t                 err_c;
    logic                        access_c;
    logic                        busy_c;
    logic                        hit;

    assign access_c = rd_en_in | wr_en_in;
    assign busy_c   = (state_q == READ) || (state_q == WRITE);

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q == IDLE),
        .en  (busy_c && !mem.mem_ack),
        .hit (hit)
    );

    // Upstream freeze and pass-through; combinational so an idle stage adds no latency.
    assign stall          = ((state_q == IDLE) && access_c) || busy_c;
    assign alu_result_out = data_alu_in;
    assign wb_en_out      = wb_en_in & ~stall;
    assign pc_en_out      = pc_en_in & ~stall;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        fault_d     = fault_q;
        code_d      = code_q;
        err_c       = FAULT_NONE;

        if (rd_en_in && wr_en_in) begin
            err_c = FAULT_CONFLICT;
        end else if (|addr_in[ARQ-1:MEMORY_ADDR_SIZE]) begin
            err_c = FAULT_RANGE;
        end

        case (state_q)
            IDLE: begin
                if (access_c) begin
                    mem_addr_d  = addr_in[MEMORY_ADDR_SIZE-1:0];
                    mem_wdata_d = mux_sel_in ? data_alu_in : data_reg_in;
                    if (err_c != FAULT_NONE) begin
                        state_d = DONE;
                        if (!fault_q) begin
                            fault_d = 1'b1;
                            code_d  = err_c;
                        end
                    end else begin
                        state_d   = rd_en_in ? READ : WRITE;
                        mem_req_d = 1'b1;
                        mem_we_d  = wr_en_in;
                    end
                end
            end
            READ, WRITE: begin
                if (mem.mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == READ) begin
                        rd_data_d  = mem.mem_rdata;
                        rd_valid_d = 1'b1;
                    end
                end else if (hit) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    rd_data_d = '0;
                    if (!fault_q) begin
                        fault_d = 1'b1;
                        code_d  = FAULT_TIMEOUT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            fault_q     <= 1'b0;
            code_q      <= FAULT_NONE;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign fault         = fault_q;
    assign fault_code    = code_q;

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage access sequencer for the 16-bit pipelined ASIP. It sits between the EXE/MEM pipeline register and the data memory, and turns one-cycle load/store requests into a req/ack transaction with multi-cycle latency. While a transaction is in flight it stalls the upstream stages and inserts bubbles toward the MEM/WB register. It also flags out-of-range addresses, read/write conflicts and memory timeouts.

## Interface
- ARQ, 16, datapath width
- MEMORY_ADDR_SIZE, 13, data-memory word-address width
- TIMEOUT, 15, maximum cycles `mem_req` is held without `mem_ack` (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- rd_en_in  in  1  load request from EXE/MEM register
- wr_en_in  in  1  store request from EXE/MEM register
- mux_sel_in  in  1  store-data source: 0 = data_reg_in, 1 = data_alu_in
- addr_in  in  ARQ  address (src3 path)
- data_alu_in  in  ARQ  ALU result; also passed through
- data_reg_in  in  ARQ  register operand (src1 path)
- wb_en_in, pc_en_in  in  1 each  writeback and PC enables, passed through
- mem_ack  in  1  memory completion strobe
- mem_rdata  in  ARQ  read data, valid when mem_ack=1
- mem_req  out  1  access request, held until ack or timeout
- mem_we  out  1  1 = write
- mem_addr  out  MEMORY_ADDR_SIZE  latched address
- mem_wdata  out  ARQ  latched store data
- stall  out  1  freeze PC, IF/ID, ID/EXE and EXE/MEM registers
- rd_valid  out  1  rd_data valid, one cycle
- rd_data  out  ARQ  load result
- alu_result_out  out  ARQ  = data_alu_in
- wb_en_out, pc_en_out  out  1 each  = wb_en_in & ~stall, pc_en_in & ~stall
- fault  out  1  sticky error flag
- fault_code  out  2  01 timeout, 10 address range, 11 rd/wr conflict; first fault wins

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- **IDLE, neither rd_en_in nor wr_en_in:**
  - stall=0.
  - All outputs follow the pass-through equations.
  - Zero added latency.
- **IDLE, access request:**
  - stall=1 this cycle.
  - Latch addr_in[MEMORY_ADDR_SIZE-1:0] and the mux-selected store data.
  - Clear the timeout counter.
- **IDLE, error checks (no memory request is issued; the FSM goes to DONE):**
  - rd_en_in & wr_en_in → code 11.
  - addr_in[ARQ-1:MEMORY_ADDR_SIZE] ≠ 0 → code 10.
  - If both apply, the conflict (11) takes priority.
- **IDLE, legal request:** go to READ (rd) or WRITE (wr).
- **READ / WRITE:**
  - mem_req=1, mem_we = (state==WRITE), stall=1.
  - Address and data are stable for the whole state.
  - Counter increments each cycle without ack.
  - On mem_ack: READ captures mem_rdata into rd_data; go to DONE.
  - If counter reaches TIMEOUT with no ack: drop req, set fault code 01, rd_data=0, go to DONE.
- **DONE:**
  - stall=0; rd_valid=1 only if the access was a successful read.
  - Inputs are ignored; next state is IDLE.
  - The upstream register advances at the end of DONE, so the same instruction is never relaunched.
- mem_ack outside READ/WRITE is ignored.
- fault/fault_code are set only when fault=0. They clear only on reset.
- Counter width: $clog2(TIMEOUT+1) bits, saturating.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - rd_valid=0, rd_data=0
  - fault=0, fault_code=00, counter=0
- stall, wb_en_out, pc_en_out and alu_result_out are combinational from state and inputs. Their value under reset is therefore 0 when the inputs are 0.
- Reset mid-transaction drops mem_req immediately; the transaction is abandoned.
- Access launched in cycle 0, ack first seen in cycle k≥1: mem_req is high in cycles 1..k and DONE is cycle k+1. Minimum occupancy is 3 cycles.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then DONE.
- Error path: IDLE (stall=1) → DONE, a 2-cycle occupancy.
- rd_valid is a one-cycle pulse in DONE, aligned with the MEM/WB capture edge.

## Structure
- Shared package `mem_stage_pkg`:
  - state enum (IDLE/READ/WRITE/DONE)
  - fault-code enum (FAULT_NONE, FAULT_TIMEOUT, FAULT_RANGE, FAULT_CONFLICT)
  - default MEMORY_ADDR_SIZE constant
- One sub-module `mem_timeout_cnt`: clear, enable and saturating count, with a `hit` output at TIMEOUT.
- The FSM, latches and output logic live in mem_stage_ctrl.

## Test plan
- **Reset:** rst=0 with random inputs → mem_req=0, rd_valid=0, rd_data=0, fault=0, code 00. Pulse rst low in the middle of READ → mem_req falls the same cycle.
- **Load:** rd_en_in=1, addr_in=0x0012, mem_ack in the 2nd req cycle with mem_rdata=0xBEEF →
  - stall=1 in cycles 0–2, mem_addr=0x0012.
  - Cycle 3: DONE, rd_valid=1, rd_data=0xBEEF, stall=0.
  - wb_en_out=0 throughout cycles 0–2.
- **Store:** wr_en_in=1, mux_sel_in=1, data_alu_in=0x1234, addr_in=0x1FFF, ack in the first req cycle → mem_we=1, mem_wdata=0x1234, mem_addr=0x1FFF, DONE in cycle 2, rd_valid=0. Repeat with mux_sel_in=0 and data_reg_in=0xA5A5 → mem_wdata=0xA5A5.
- **Timeout:** TIMEOUT=15, read, never ack → mem_req high for 15 cycles then 0, fault=1 with code 01, rd_data=0. A later late ack is ignored.
- **Range and conflict:**
  - addr_in=0x2000 with a read → no mem_req, code 10, stall high for exactly 1 cycle.
  - After reset, rd_en_in=wr_en_in=1 → code 11.
  - A subsequent timeout leaves the code unchanged.
- **Back-to-back:** two loads in consecutive instructions, each with immediate ack → two rd_valid pulses 3 cycles apart, with no instruction repeated or dropped.
